// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate plus register/funct/opcode fields into an RV32I word.
// Two-stage valid/ready pipeline with saturating encode and error counters.
module imm_encoder #(
    parameter int CNT_W  = 16,
    parameter bit STRICT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_src,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0]  IMM_I_TYPE = 3'd0;
    localparam logic [2:0]  IMM_S_TYPE = 3'd1;
    localparam logic [2:0]  IMM_B_TYPE = 3'd2;
    localparam logic [2:0]  IMM_U_TYPE = 3'd3;
    localparam logic [2:0]  IMM_J_TYPE = 3'd4;
    localparam logic [2:0]  IMM_R_TYPE = 3'd5;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  src;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    fields_t          s1_q, s1_d;
    logic             s1_v_q, s1_v_d;
    logic             s1_err_q, s1_err_d;
    logic             s2_v_q, s2_v_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             s1_load, s2_load, handoff, in_err;
    logic [31:0]      packed_word;

    assign s2_load   = !s2_v_q || out_ready;
    assign s1_load   = !s1_v_q || s2_load;
    assign in_ready  = s1_load;
    assign handoff   = s2_v_q && out_ready;

    // An immediate fits when the bits above the format's field are pure sign extension.
    always_comb begin
        in_err = 1'b0;
        case (imm_src)
            IMM_I_TYPE, IMM_S_TYPE: in_err = !((&imm[31:11]) || !(|imm[31:11]));
            IMM_B_TYPE: in_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
            IMM_J_TYPE: in_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
            IMM_U_TYPE: in_err = |imm[11:0];
            IMM_R_TYPE: in_err = 1'b0;
            default:    in_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_d     = s1_q;
        s1_err_d = s1_err_q;
        if (s1_load) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_d.src    = imm_src;
                s1_d.opcode = opcode;
                s1_d.rd     = rd;
                s1_d.rs1    = rs1;
                s1_d.rs2    = rs2;
                s1_d.funct3 = funct3;
                s1_d.funct7 = funct7;
                s1_d.imm    = imm;
                s1_err_d    = in_err;
            end
        end
    end

    // Illegal formats fall through to the R-type packing.
    always_comb begin
        packed_word = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
        case (s1_q.src)
            IMM_I_TYPE: packed_word = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
            IMM_S_TYPE: packed_word = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                       s1_q.imm[4:0], s1_q.opcode};
            IMM_B_TYPE: packed_word = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                       s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
            IMM_U_TYPE: packed_word = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
            IMM_J_TYPE: packed_word = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                                       s1_q.rd, s1_q.opcode};
            default:    ;
        endcase
    end

    always_comb begin
        s2_v_d  = s2_v_q;
        instr_d = instr_q;
        err_d   = err_q;
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                err_d   = s1_err_q;
                instr_d = (STRICT && s1_err_q) ? NOP : packed_word;
            end
        end
    end

    always_comb begin
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (handoff && (enc_cnt_q != '1)) enc_cnt_d = enc_cnt_q + CNT_W'(1);
        if (handoff && err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_q      <= '0;
            s1_err_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            instr_q   <= '0;
            err_q     <= 1'b0;
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_q      <= s1_d;
            s1_err_q  <= s1_err_d;
            s2_v_q    <= s2_v_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign enc_cnt   = enc_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder with a reference packer and extender.
// A second instance (CNT_W=2, STRICT=0) runs in lockstep for saturation and raw packing.
module tb_imm_encoder;

    localparam logic [2:0] I_T = 3'd0;
    localparam logic [2:0] S_T = 3'd1;
    localparam logic [2:0] B_T = 3'd2;
    localparam logic [2:0] U_T = 3'd3;
    localparam logic [2:0] J_T = 3'd4;
    localparam logic [2:0] R_T = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  imm_src = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [15:0] enc_cnt, err_cnt;
    logic        s_in_ready, s_out_valid, s_out_err;
    logic [31:0] s_out_instr;
    logic [1:0]  s_enc_cnt, s_err_cnt;

    imm_encoder #(.CNT_W(16), .STRICT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    imm_encoder #(.CNT_W(2), .STRICT(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .imm_src(imm_src), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
        .out_err(s_out_err), .enc_cnt(s_enc_cnt), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] raw;
        logic [31:0] imm;
        logic        err;
        logic [2:0]  src;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   model_enc = 0;
    int   model_err = 0;
    bit   rand_ready = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference packer: field placement by shifts and masks, range checks on the signed value.
    function automatic void refModel(input logic [2:0] src, input logic [6:0] opc, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] im,
                                     output logic [31:0] raw, output logic err);
        int          si;
        logic [31:0] rtype;
        si    = im;
        rtype = (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
              | (32'(d) << 7) | 32'(opc);
        err   = 1'b0;
        raw   = rtype;
        case (src)
            I_T: begin
                err = (si < -2048) || (si > 2047);
                raw = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(opc);
            end
            S_T: begin
                err = (si < -2048) || (si > 2047);
                raw = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                    | (32'(f3) << 12) | ((im & 32'h1F) << 7) | 32'(opc);
            end
            B_T: begin
                err = ((im & 32'h1) != 0) || (si < -4096) || (si > 4095);
                raw = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                    | (32'(s1) << 15) | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 11) & 32'h1) << 7) | 32'(opc);
            end
            J_T: begin
                err = ((im & 32'h1) != 0) || (si < -(1 << 20)) || (si > (1 << 20) - 1);
                raw = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                    | (32'(d) << 7) | 32'(opc);
            end
            U_T: begin
                err = (im & 32'hFFF) != 0;
                raw = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(opc);
            end
            R_T:     err = 1'b0;
            default: err = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] src);
        case (src)
            I_T:     return {{20{w[31]}}, w[31:20]};
            S_T:     return {{20{w[31]}}, w[31:25], w[11:7]};
            B_T:     return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            U_T:     return {w[31:12], 12'b0};
            J_T:     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] genImm(input logic [2:0] src);
        int v;
        case (src)
            I_T, S_T: v = int'($urandom_range(0, 4095)) - 2048;
            B_T:      v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            J_T:      v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
            U_T:      v = int'($urandom & 32'hFFFF_F000);
            default:  v = int'($urandom);
        endcase
        return 32'(v);
    endfunction

    task automatic applyStimulus(input logic [2:0] src, input logic [6:0] opc, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] im);
        exp_t e;
        bit   accepted;
        refModel(src, opc, d, s1, s2, f3, f7, im, e.raw, e.err);
        e.instr  = e.err ? 32'h0000_0013 : e.raw;
        e.imm    = im;
        e.src    = src;
        imm_src  = src;
        opcode   = opc;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
        imm      = im;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_enc_cnt", 32'(enc_cnt), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int c = 0; c < 100 && (sb.size() != 0 || out_valid); c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: counters against the model every cycle, outputs held while stalled, pop on handoff.
    initial begin
        exp_t        e;
        bit          prev_stall;
        logic [31:0] prev_instr;
        logic        prev_err;
        prev_stall = 1'b0;
        prev_instr = '0;
        prev_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                model_enc  = 0;
                model_err  = 0;
                prev_stall = 1'b0;
            end else begin
                checkOutput("enc_cnt", 32'(enc_cnt), 32'((model_enc > 65535) ? 65535 : model_enc));
                checkOutput("err_cnt", 32'(err_cnt), 32'((model_err > 65535) ? 65535 : model_err));
                checkOutput("sat_enc_cnt", 32'(s_enc_cnt), 32'((model_enc > 3) ? 3 : model_enc));
                checkOutput("sat_err_cnt", 32'(s_err_cnt), 32'((model_err > 3) ? 3 : model_err));
                if (prev_stall) begin
                    checkOutput("stall_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall_instr", out_instr, prev_instr);
                    checkOutput("stall_err", 32'(out_err), 32'(prev_err));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_output", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("out_instr", out_instr, e.instr);
                        checkOutput("out_err", 32'(out_err), 32'(e.err));
                        checkOutput("sat_out_valid", 32'(s_out_valid), 32'd1);
                        checkOutput("sat_out_instr", s_out_instr, e.raw);
                        checkOutput("sat_out_err", 32'(s_out_err), 32'(e.err));
                        if (!e.err && e.src != R_T)
                            checkOutput("round_trip", extend(out_instr, e.src), e.imm);
                        model_enc++;
                        if (e.err) model_err++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_instr = out_instr;
                prev_err   = out_err;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  src;
        logic [31:0] im;
        @(posedge clk);
        #1;
        doReset();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,-1 with a latency check.
        applyStimulus(I_T, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("lat_first_cycle", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_second_cycle", 32'(out_valid), 32'd1);
        checkOutput("addi_instr", out_instr, 32'hFFF0_0093);
        @(posedge clk);
        #1;

        applyStimulus(B_T, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0FFE);
        applyStimulus(B_T, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_1001);
        applyStimulus(U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        applyStimulus(U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        applyStimulus(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'h0);
        drain();

        // Two words in flight when reset hits.
        applyStimulus(I_T, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'h0000_0005);
        applyStimulus(S_T, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'hFFFF_FFF0);
        doReset();

        // Eight-word stream with out_ready low for four cycles.
        fork
            begin
                for (int k = 0; k < 8; k++)
                    applyStimulus(I_T, 7'h13, 5'(k + 1), 5'(k), 5'd0, 3'd0, 7'd0, 32'(k * 17 - 40));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk);
        checkOutput("stream_enc_cnt", 32'(enc_cnt), 32'd8);
        checkOutput("stream_sat_enc_cnt", 32'(s_enc_cnt), 32'd3);
        @(posedge clk);
        #1;

        // Randomized fields, formats and backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            src = 3'($urandom_range(0, 7));
            if (src > 3'd5 && $urandom_range(0, 3) != 0) src = 3'($urandom_range(0, 5));
            im = ($urandom_range(0, 9) < 2) ? $urandom : genImm(src);
            applyStimulus(src, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                          3'($urandom), 7'($urandom), im);
        end
        drain();
        @(negedge clk);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
